fright_controller: RTL and testbench
====================================

Name: fright_controller

Overview:
- Consumer end of the power-pellet handshake from the dot/score block.
- Accepts each ate_pellet event and returns the pellet_ack clear strobe.
- Runs the ghost frightened timer, including the end-of-fright flashing phase.
- Scores frightened-ghost captures with the 200/400/800/1600 chain and feeds bonus points to the score path; ghost sprite/AI blocks read frightened and flash.

Parameters:
- FRIGHT_FRAMES, 360, total frightened duration in frame ticks (60 Hz → 6 s).
- FLASH_FRAMES, 120, final portion of the fright in which flash toggles; must be < FRIGHT_FRAMES.
- FLASH_PERIOD, 8, frame ticks between flash toggles.
- CW, 10, remaining-frame counter width; must satisfy 2^CW > FRIGHT_FRAMES.

Ports:
- Clk input 1: system clock; the only clock.
- Reset input 1: synchronous, active-high.
- hard_reset input 1: game restart; synchronous clear, same effect as Reset.
- new_map input 1: level cleared; synchronous clear, same effect as Reset.
- frame_clk input 1: vertical-sync level, sampled on Clk. It is never used as a clock.
- ate_pellet input 1: power-pellet event request, level.
- ghost_collide input 4: per-ghost overlap with Pac-Man, level; bit i is ghost i.
- pellet_ack output 1: handshake acknowledge back to the dot/score block.
- frightened output 4: per-ghost frightened flag.
- flash output 1: frightened sprites render white when 1.
- bonus_valid output 1: one-cycle strobe; add bonus_points to the score.
- bonus_points output 11: capture value (200/400/800/1600).
- frames_left output CW: remaining fright frames; 0 when idle.

Behaviour:
Reset and clears
- Reset, hard_reset or new_map clears the block on the next Clk edge and has top priority over all other inputs.
- Cleared values: pellet_ack=0, frightened=0, flash=0, bonus_valid=0, bonus_points=0, frames_left=0, chain=200, flash phase counter=0, frame_clk sample register=0, state=IDLE.

Frame tick
- tick = frame_clk & ~frame_clk_q, where frame_clk_q is frame_clk registered on Clk.
- tick is high for exactly one Clk cycle per frame.

Handshake (4-phase)
- accept = ate_pellet & ~pellet_ack.
- pellet_ack goes to 1 the cycle after accept and holds while ate_pellet=1.
- pellet_ack returns to 0 the cycle after ate_pellet is sampled 0.
- Exactly one event per handshake; a held ate_pellet never retriggers.

State machine: IDLE, FRIGHT, FLASH
- Any state, accept → FRIGHT:
  - frightened=4'hF, frames_left=FRIGHT_FRAMES, chain=200, flash=0, phase=0.
  - Re-accept during FRIGHT or FLASH restarts fully, including re-frightening ghosts already eaten.
  - accept and tick in the same cycle: the load wins; no decrement that cycle.
- FRIGHT: frames_left decrements by 1 per tick.
  - When the decremented value equals FLASH_FRAMES → FLASH, with flash=1 and phase=0.
- FLASH: decrement per tick.
  - phase increments per tick; when phase reaches FLASH_PERIOD-1, flash toggles and phase returns to 0.
  - When frames_left reaches 0 → IDLE, with frightened=0 and flash=0.
- FRIGHT or FLASH with frightened becoming 0 (all ghosts eaten) → IDLE on the following cycle; frames_left=0, flash=0.

Captures
- Each cycle, the lowest index i with ghost_collide[i] & frightened[i] is served.
- On service: frightened[i] clears; the next cycle bonus_valid=1 and bonus_points=chain.
- chain doubles after each capture and saturates at 1600.
- Other simultaneous colliders are served on successive cycles while their collide level stays high.
- Collisions with non-frightened ghosts are ignored; death is handled elsewhere.
- accept in the same cycle as a collision: accept wins and that capture is dropped.
- bonus_points holds its last value between strobes.

Test Plan:
Use FRIGHT_FRAMES=10, FLASH_FRAMES=4, FLASH_PERIOD=2 unless stated.
1. Handshake: ate_pellet=1 for 5 cycles, then 0.
   - pellet_ack rises 1 cycle after ate_pellet, falls 1 cycle after ate_pellet drops.
   - frightened=F, frames_left=10, only one load.
2. Timer: 10 ticks, no collisions.
   - frames_left 9…0.
   - FLASH entered at frames_left=4 with flash=1; flash toggles every 2 ticks.
   - At 0: frightened=0, flash=0, state IDLE.
3. Chain: ghosts 0,1,2,3 collide one at a time.
   - bonus_points 200, 400, 800, 1600, each with one bonus_valid pulse.
   - After the fourth capture, IDLE and frames_left=0.
4. Simultaneous collision: ghost_collide=4'b0110 held.
   - Ghost1 is served first (200), ghost2 next cycle (400).
   - The held level produces no further strobes.
5. Re-accept: second pellet at frames_left=3 after 2 captures.
   - frames_left=10, frightened=F, next capture scores 200.
6. Clear priority: new_map asserted in the same cycle as accept and a collision.
   - All outputs are 0 the next cycle; no pellet_ack, no bonus_valid.

Source files
------------

// File: rtl/fright_controller.sv
// fright_controller: power-pellet handshake, ghost frightened/flash timer and capture bonus chain
// Ports: Clk clock; Reset/hard_reset/new_map synchronous clears; frame_clk vsync level sampled on Clk;
//        ate_pellet pellet request level; ghost_collide per-ghost overlap; pellet_ack handshake acknowledge;
//        frightened per-ghost flag; flash white-sprite phase; bonus_valid/bonus_points capture score strobe;
//        frames_left remaining fright frames.
module fright_controller #(
   parameter int FRIGHT_FRAMES = 360,
   parameter int FLASH_FRAMES  = 120,
   parameter int FLASH_PERIOD  = 8,
   parameter int CW            = 10
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          hard_reset,
   input  logic          new_map,
   input  logic          frame_clk,
   input  logic          ate_pellet,
   input  logic [3:0]    ghost_collide,
   output logic          pellet_ack,
   output logic [3:0]    frightened,
   output logic          flash,
   output logic          bonus_valid,
   output logic [10:0]   bonus_points,
   output logic [CW-1:0] frames_left
);
   localparam int PW = FLASH_PERIOD > 1 ? $clog2(FLASH_PERIOD) : 1;
   typedef enum logic [1:0] {IDLE, FRIGHT, FLASH} state_t;
   state_t state, state_n;
   logic clr, tick, accept, frame_clk_q;
   logic [3:0] hit, low;
   logic [PW-1:0] phase, phase_n;
   logic [10:0] chain, chain_n, bonus_points_n;
   logic [3:0] frightened_n;
   logic flash_n, bonus_valid_n;
   logic [CW-1:0] frames_left_n;
   assign clr    = Reset | hard_reset | new_map;
   assign tick   = frame_clk & ~frame_clk_q;
   assign accept = ate_pellet & ~pellet_ack;
   assign hit    = ghost_collide & frightened;
   // isolate the lowest set bit: that ghost is served this cycle
   assign low    = hit & (~hit + 4'd1);
   always_ff @(posedge Clk) begin
      if (clr) begin
         state        <= IDLE;
         frame_clk_q  <= 1'b0;
         pellet_ack   <= 1'b0;
         frightened   <= 4'h0;
         flash        <= 1'b0;
         bonus_valid  <= 1'b0;
         bonus_points <= 11'd0;
         frames_left  <= '0;
         chain        <= 11'd200;
         phase        <= '0;
      end else begin
         state        <= state_n;
         frame_clk_q  <= frame_clk;
         // ack follows the request level, giving a 4-phase handshake
         pellet_ack   <= ate_pellet;
         frightened   <= frightened_n;
         flash        <= flash_n;
         bonus_valid  <= bonus_valid_n;
         bonus_points <= bonus_points_n;
         frames_left  <= frames_left_n;
         chain        <= chain_n;
         phase        <= phase_n;
      end
   end
   always_comb begin
      state_n        = state;
      frightened_n   = frightened;
      flash_n        = flash;
      bonus_valid_n  = 1'b0;
      bonus_points_n = bonus_points;
      frames_left_n  = frames_left;
      chain_n        = chain;
      phase_n        = phase;
      if (accept) begin
         state_n       = FRIGHT;
         frightened_n  = 4'hF;
         frames_left_n = CW'(FRIGHT_FRAMES);
         chain_n       = 11'd200;
         flash_n       = 1'b0;
         phase_n       = '0;
      end else begin
         if (|hit) begin
            frightened_n   = frightened & ~low;
            bonus_valid_n  = 1'b1;
            bonus_points_n = chain;
            chain_n        = chain == 11'd1600 ? chain : chain << 1;
         end
         if (state != IDLE) begin
            if (frightened == 4'h0) begin
               state_n       = IDLE;
               frames_left_n = '0;
               flash_n       = 1'b0;
               phase_n       = '0;
            end else if (tick) begin
               frames_left_n = frames_left - 1'b1;
               if (state == FRIGHT) begin
                  if (frames_left_n == CW'(FLASH_FRAMES)) begin
                     state_n = FLASH;
                     flash_n = 1'b1;
                     phase_n = '0;
                  end
               end else if (frames_left_n == '0) begin
                  state_n      = IDLE;
                  frightened_n = 4'h0;
                  flash_n      = 1'b0;
                  phase_n      = '0;
               end else if (phase == PW'(FLASH_PERIOD - 1)) begin
                  flash_n = ~flash;
                  phase_n = '0;
               end else begin
                  phase_n = phase + 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_fright_controller.sv
// tb_fright_controller: directed self-checking bench for fright_controller
module tb_fright_controller;
   logic Clk = 1'b0, Reset = 1'b1, hard_reset = 1'b0, new_map = 1'b0, frame_clk = 1'b0, ate_pellet = 1'b0;
   logic [3:0] ghost_collide = 4'h0;
   logic pellet_ack, flash, bonus_valid;
   logic [3:0] frightened;
   logic [10:0] bonus_points;
   logic [9:0] frames_left;
   int n_cmp = 0, n_bad = 0;
   fright_controller #(.FRIGHT_FRAMES(10), .FLASH_FRAMES(4), .FLASH_PERIOD(2), .CW(10)) dut (
      .Clk(Clk), .Reset(Reset), .hard_reset(hard_reset), .new_map(new_map), .frame_clk(frame_clk),
      .ate_pellet(ate_pellet), .ghost_collide(ghost_collide), .pellet_ack(pellet_ack),
      .frightened(frightened), .flash(flash), .bonus_valid(bonus_valid),
      .bonus_points(bonus_points), .frames_left(frames_left)
   );
   always #5 Clk = ~Clk;
   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask
   task automatic tick();
      frame_clk = 1'b1;
      cyc();
      frame_clk = 1'b0;
      cyc();
   endtask
   task automatic pellet();
      ate_pellet = 1'b1;
      cyc();
      ate_pellet = 1'b0;
      cyc();
   endtask
   task automatic capture(input int g, input int pts, input int fr);
      ghost_collide = 4'(1 << g);
      cyc();
      chk("cap_valid", bonus_valid, 1);
      chk("cap_points", bonus_points, pts);
      chk("cap_fright", frightened, fr);
      ghost_collide = 4'h0;
      cyc();
      chk("cap_valid_off", bonus_valid, 0);
      chk("cap_points_hold", bonus_points, pts);
   endtask
   int flash_exp[10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
   initial begin
      cyc();
      cyc();
      Reset = 1'b0;
      chk("rst_ack", pellet_ack, 0);
      chk("rst_fright", frightened, 0);
      chk("rst_flash", flash, 0);
      chk("rst_valid", bonus_valid, 0);
      chk("rst_points", bonus_points, 0);
      chk("rst_frames", frames_left, 0);
      // handshake: request held 5 cycles, with a tick inside to expose a reload
      ate_pellet = 1'b1;
      #1;
      chk("hs_ack_pre", pellet_ack, 0);
      cyc();
      chk("hs_ack_rise", pellet_ack, 1);
      chk("hs_fright", frightened, 15);
      chk("hs_frames", frames_left, 10);
      tick();
      cyc();
      cyc();
      chk("hs_ack_hold", pellet_ack, 1);
      chk("hs_single_load", frames_left, 9);
      ate_pellet = 1'b0;
      cyc();
      chk("hs_ack_fall", pellet_ack, 0);
      // timer through flash to idle
      pellet();
      chk("tm_load", frames_left, 10);
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("tm_frames_%0d", k), frames_left, 10 - k);
         chk($sformatf("tm_flash_%0d", k), flash, flash_exp[k-1]);
         chk($sformatf("tm_fright_%0d", k), frightened, k < 10 ? 15 : 0);
      end
      tick();
      chk("tm_idle_frames", frames_left, 0);
      // capture chain
      pellet();
      capture(0, 200, 4'hE);
      capture(1, 400, 4'hC);
      capture(2, 800, 4'h8);
      capture(3, 1600, 4'h0);
      chk("ch_idle_frames", frames_left, 0);
      chk("ch_idle_fright", frightened, 0);
      // simultaneous colliders held
      pellet();
      ghost_collide = 4'b0110;
      cyc();
      chk("sim_v1", bonus_valid, 1);
      chk("sim_p1", bonus_points, 200);
      chk("sim_f1", frightened, 4'hD);
      cyc();
      chk("sim_v2", bonus_valid, 1);
      chk("sim_p2", bonus_points, 400);
      chk("sim_f2", frightened, 4'h9);
      cyc();
      chk("sim_v3", bonus_valid, 0);
      cyc();
      chk("sim_v4", bonus_valid, 0);
      chk("sim_p4", bonus_points, 400);
      ghost_collide = 4'h0;
      // re-accept during flash after two captures
      pellet();
      capture(0, 200, 4'hE);
      capture(1, 400, 4'hC);
      for (int k = 0; k < 7; k++) tick();
      chk("ra_frames_pre", frames_left, 3);
      chk("ra_flash_pre", flash, 1);
      pellet();
      chk("ra_frames", frames_left, 10);
      chk("ra_fright", frightened, 15);
      chk("ra_flash", flash, 0);
      capture(2, 200, 4'hB);
      // clear wins over accept and collision
      new_map = 1'b1;
      ate_pellet = 1'b1;
      ghost_collide = 4'h1;
      cyc();
      chk("clr_ack", pellet_ack, 0);
      chk("clr_valid", bonus_valid, 0);
      chk("clr_fright", frightened, 0);
      chk("clr_frames", frames_left, 0);
      chk("clr_points", bonus_points, 0);
      chk("clr_flash", flash, 0);
      new_map = 1'b0;
      ate_pellet = 1'b0;
      ghost_collide = 4'h0;
      cyc();
      pellet();
      hard_reset = 1'b1;
      cyc();
      hard_reset = 1'b0;
      chk("hr_fright", frightened, 0);
      chk("hr_frames", frames_left, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
